// File: rtl/hs_channel_arbiter_pkg.sv
// Shared types and helpers for the handshake-channel arbiter.
package hs_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_ACK_HI, WAIT_ACK_LO, DONE} hs_arb_state_t;

  // Index width for a requester count; never narrower than one bit.
  function automatic int ID_W(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // (i mod n) for 0 <= i < 2n, avoiding a real divider.
  function automatic int wrapIdx(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: rotate by ptr, find first set, unrotate.
module rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = ID_W(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   first;

  always_comb begin
    rot = '0;
    for (int k = 0; k < NREQ; k++) rot[k] = req[wrapIdx(k + int'(ptr), NREQ)];
  end

  // Scan downward so the lowest rotated position wins.
  always_comb begin
    first = '0;
    any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        first = IW'(k);
        any   = 1'b1;
      end
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = any ? IW'(wrapIdx(int'(first) + int'(ptr), NREQ)) : '0;
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/hs_channel_arbiter.sv
// Round-robin sequencer sharing one four-phase handshake channel among NREQ requesters.
// Optional ack timeout/abort enabled by defining HS_ARB_TIMEOUT_EN.
module hs_channel_arbiter
  import hs_arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk1,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*N-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    validIn,
  output logic [N-1:0]            dataIn,
  input  logic                    ready,
  output logic                    xfer_done,
  output logic [ID_W(NREQ)-1:0]   xfer_id,
  output logic                    xfer_err,
  output logic                    busy
);

  localparam int IW = ID_W(NREQ);

  hs_arb_state_t stateQ, stateNext;
  logic [IW-1:0]   ptrQ, idQ, gntIdx, ptrInc;
  logic [NREQ-1:0] gnt;
  logic            anyReq, grantEn, ackHi, timeoutHit, errQ;

  rr_arbiter #(.NREQ(NREQ)) uArb (
    .req     (req_valid),
    .ptr     (ptrQ),
    .gnt     (gnt),
    .gnt_idx (gntIdx),
    .any     (anyReq)
  );

  assign ptrInc = (gntIdx == IW'(NREQ - 1)) ? '0 : gntIdx + IW'(1);

  always_comb begin
    stateNext = stateQ;
    grantEn   = 1'b0;
    ackHi     = 1'b0;
    case (stateQ)
      IDLE:        if (anyReq) begin grantEn = 1'b1; stateNext = WAIT_ACK_HI; end
      WAIT_ACK_HI: if (ready || timeoutHit) begin ackHi = 1'b1; stateNext = WAIT_ACK_LO; end
      WAIT_ACK_LO: if (!ready) stateNext = DONE;
      DONE:        stateNext = IDLE;
      default:     stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      stateQ  <= IDLE;
      ptrQ    <= '0;
      idQ     <= '0;
      dataIn  <= '0;
      validIn <= 1'b0;
      busy    <= 1'b0;
    end else begin
      stateQ <= stateNext;
      busy   <= (stateNext != IDLE);
      if (grantEn) begin
        dataIn  <= req_data[gntIdx*N +: N];
        idQ     <= gntIdx;
        ptrQ    <= ptrInc;
        validIn <= 1'b1;
      end else if (ackHi) begin
        validIn <= 1'b0;
      end
    end
  end

`ifdef HS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] toCnt;

  // Fires on the edge where the count would reach TIMEOUT, so validIn is high exactly TIMEOUT cycles.
  assign timeoutHit = (stateQ == WAIT_ACK_HI) && !ready && (toCnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      toCnt <= '0;
      errQ  <= 1'b0;
    end else if (grantEn) begin
      toCnt <= '0;
      errQ  <= 1'b0;
    end else begin
      if (stateQ == WAIT_ACK_HI && !ready) toCnt <= toCnt + CW'(1);
      if (timeoutHit) errQ <= 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign errQ       = 1'b0;
`endif

  // Grant is suppressed while reset is held so req_ready shows its reset value immediately.
  assign req_ready = (stateQ == IDLE && !reset) ? gnt : '0;
  assign xfer_done = (stateQ == DONE);
  assign xfer_id   = xfer_done ? idQ : '0;
  assign xfer_err  = xfer_done & errQ;

endmodule

// File: tb/tb_hs_channel_arbiter.sv
// Scoreboarded bench for hs_channel_arbiter; grants push expectations, xfer_done pops them.
module tb_hs_channel_arbiter;

  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IW      = 2;

  logic              clk1 = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              validIn;
  logic [N-1:0]      dataIn;
  logic              ready = 1'b0;
  logic              xfer_done;
  logic [IW-1:0]     xfer_id;
  logic              xfer_err;
  logic              busy;

  hs_channel_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk1(clk1), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .validIn(validIn), .dataIn(dataIn), .ready(ready),
    .xfer_done(xfer_done), .xfer_id(xfer_id), .xfer_err(xfer_err), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  typedef struct { logic [IW-1:0] id; logic [N-1:0] data; logic err; } exp_t;
  exp_t sb[$];
  int   nTests = 0;
  int   nFail  = 0;
  int   mPtr   = 0;
  logic expErr = 1'b0;

  // Reference round-robin model and scoreboard, sampled on the falling edge.
  int              mw;
  logic [NREQ-1:0] meh;
  exp_t            me;
  always @(negedge clk1) begin
    if (reset) begin
      sb.delete();
      mPtr = 0;
    end else begin
      if (busy) begin
        nTests++;
        if (req_ready !== '0) begin nFail++; $display("FAIL ready_outside_idle: got %b required 0000", req_ready); end
      end else if (req_valid != '0) begin
        mw = -1;
        for (int k = 0; k < NREQ; k++) if (mw < 0 && req_valid[(mPtr + k) % NREQ]) mw = (mPtr + k) % NREQ;
        meh = '0;
        meh[mw] = 1'b1;
        nTests++;
        if (req_ready !== meh) begin nFail++; $display("FAIL grant_onehot: got %b required %b", req_ready, meh); end
        me.id = mw[IW-1:0];
        me.data = req_data[mw*N +: N];
        me.err = expErr;
        sb.push_back(me);
        mPtr = (mw + 1) % NREQ;
      end
      if (validIn && sb.size() > 0) begin
        nTests++;
        if (dataIn !== sb[0].data) begin nFail++; $display("FAIL data_stable: got %h required %h", dataIn, sb[0].data); end
      end
      if (xfer_done) begin
        nTests++;
        if (sb.size() == 0) begin
          nFail++; $display("FAIL done_unexpected: got xfer_done with empty scoreboard");
        end else begin
          me = sb.pop_front();
          if (xfer_id !== me.id || xfer_err !== me.err || dataIn !== me.data) begin
            nFail++;
            $display("FAIL done_result: got id=%0d err=%b data=%h required id=%0d err=%b data=%h",
                     xfer_id, xfer_err, dataIn, me.id, me.err, me.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    nTests++;
    if ({validIn, dataIn, req_ready, xfer_done, xfer_id, xfer_err, busy} !== '0) begin
      nFail++; $display("FAIL reset_outputs: got v=%b d=%h rr=%b done=%b id=%0d err=%b busy=%b required all 0",
                        validIn, dataIn, req_ready, xfer_done, xfer_id, xfer_err, busy);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    nTests++;
    if (busy !== 1'b0 || validIn !== 1'b0) begin nFail++; $display("FAIL reset_idle: got busy=%b validIn=%b required 0 0", busy, validIn); end
  endtask

  task automatic test_fairness();
    int k = 0, done = 0, cyc = 0, last = 0;
    logic [NREQ-1:0] e;
    for (int i = 0; i < NREQ; i++) req_data[i*N +: N] = N'(8'h10 + i);
    req_valid = '1;
    ready = 1'b0;
    #1;
    while (done < 8 && cyc < 100) begin
      if (req_ready != '0) begin
        e = '0;
        e[k % NREQ] = 1'b1;
        nTests++;
        if (req_ready !== e) begin nFail++; $display("FAIL fair_order: grant %0d got %b required %b", k, req_ready, e); end
        if (k > 0) begin
          nTests++;
          if (cyc - last != 4) begin nFail++; $display("FAIL fair_spacing: got %0d cycles required 4", cyc - last); end
        end
        last = cyc;
        k++;
      end
      if (xfer_done) done++;
      ready = validIn;
      tick();
      cyc++;
    end
    req_valid = '0;
    ready = 1'b0;
    nTests++;
    if (done != 8) begin nFail++; $display("FAIL fair_count: got %0d transfers required 8", done); end
    tick(); tick();
  endtask

  task automatic test_single();
    int bad = 0;
    req_data = '0;
    req_data[2*N +: N] = 8'hAA;
    req_data[0 +: N] = 8'h11;
    req_valid = 4'b0100;
    #1;
    nTests++;
    if (req_ready !== 4'b0100) begin nFail++; $display("FAIL single_grant: got %b required 0100", req_ready); end
    tick();
    req_valid = '0;
    repeat (3) begin
      if (validIn !== 1'b1 || dataIn !== 8'hAA) bad++;
      tick();
    end
    nTests++;
    if (bad != 0) begin nFail++; $display("FAIL single_hold: got %0d bad cycles required 0", bad); end
    ready = 1'b1;
    tick();
    nTests++;
    if (validIn !== 1'b0) begin nFail++; $display("FAIL single_ack_fall: got validIn=%b required 0", validIn); end
    repeat (3) tick();
    nTests++;
    if (xfer_done !== 1'b0 || busy !== 1'b1) begin nFail++; $display("FAIL single_wait_lo: got done=%b busy=%b required 0 1", xfer_done, busy); end
    ready = 1'b0;
    tick();
    nTests++;
    if (xfer_done !== 1'b1 || xfer_id !== 2'd2 || xfer_err !== 1'b0) begin
      nFail++; $display("FAIL single_done: got done=%b id=%0d err=%b required 1 2 0", xfer_done, xfer_id, xfer_err);
    end
    tick();
    nTests++;
    if (xfer_done !== 1'b0 || busy !== 1'b0 || dataIn !== 8'hAA) begin
      nFail++; $display("FAIL single_after: got done=%b busy=%b data=%h required 0 0 aa", xfer_done, busy, dataIn);
    end
  endtask

  task automatic test_stale_ack();
    ready = 1'b1;
    req_data[0 +: N] = 8'h5C;
    req_valid = 4'b0001;
    #1;
    nTests++;
    if (req_ready !== 4'b0001) begin nFail++; $display("FAIL stale_grant: got %b required 0001", req_ready); end
    tick();
    req_valid = '0;
    nTests++;
    if (validIn !== 1'b1) begin nFail++; $display("FAIL stale_rise: got validIn=%b required 1", validIn); end
    tick();
    nTests++;
    if (validIn !== 1'b0) begin nFail++; $display("FAIL stale_dwell: got validIn=%b required 0", validIn); end
    tick(); tick();
    nTests++;
    if (xfer_done !== 1'b0 || busy !== 1'b1) begin nFail++; $display("FAIL stale_wait_lo: got done=%b busy=%b required 0 1", xfer_done, busy); end
    ready = 1'b0;
    tick();
    nTests++;
    if (xfer_done !== 1'b1 || xfer_id !== 2'd0) begin nFail++; $display("FAIL stale_done: got done=%b id=%0d required 1 0", xfer_done, xfer_id); end
    tick();
  endtask

  task automatic test_reset_mid();
    req_data[1*N +: N] = 8'h3E;
    req_valid = 4'b0110;
    #1;
    nTests++;
    if (req_ready !== 4'b0010) begin nFail++; $display("FAIL mid_grant: got %b required 0010", req_ready); end
    tick();
    req_valid = '0;
    ready = 1'b1;
    tick();
    nTests++;
    if (busy !== 1'b1 || validIn !== 1'b0) begin nFail++; $display("FAIL mid_wait_lo: got busy=%b validIn=%b required 1 0", busy, validIn); end
    reset = 1'b1;
    req_data[2*N +: N] = 8'h77;
    req_data[3*N +: N] = 8'h88;
    req_valid = 4'b1100;
    #1;
    nTests++;
    if ({validIn, dataIn, req_ready, xfer_done, xfer_id, xfer_err, busy} !== '0) begin
      nFail++; $display("FAIL mid_async_reset: got v=%b d=%h rr=%b done=%b id=%0d err=%b busy=%b required all 0",
                        validIn, dataIn, req_ready, xfer_done, xfer_id, xfer_err, busy);
    end
    tick(); tick();
    ready = 1'b0;
    reset = 1'b0;
    #1;
    nTests++;
    if (req_ready !== 4'b0100) begin nFail++; $display("FAIL mid_ptr_cleared: got %b required 0100", req_ready); end
    tick();
    req_valid = '0;
    nTests++;
    if (validIn !== 1'b1 || dataIn !== 8'h77) begin nFail++; $display("FAIL mid_regrant: got v=%b d=%h required 1 77", validIn, dataIn); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    nTests++;
    if (xfer_done !== 1'b1 || xfer_id !== 2'd2) begin nFail++; $display("FAIL mid_done: got done=%b id=%0d required 1 2", xfer_done, xfer_id); end
    tick();
  endtask

`ifdef HS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cnt = 0;
    ready = 1'b0;
    req_data[0 +: N] = 8'h9D;
    expErr = 1'b1;
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    expErr = 1'b0;
    while (validIn === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    nTests++;
    if (cnt != TIMEOUT) begin nFail++; $display("FAIL timeout_len: got %0d cycles required %0d", cnt, TIMEOUT); end
    nTests++;
    if (xfer_done !== 1'b0) begin nFail++; $display("FAIL timeout_early_done: got %b required 0", xfer_done); end
    tick();
    nTests++;
    if (xfer_done !== 1'b1 || xfer_err !== 1'b1) begin nFail++; $display("FAIL timeout_err: got done=%b err=%b required 1 1", xfer_done, xfer_err); end
    tick();
    req_data[1*N +: N] = 8'h42;
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = '0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    nTests++;
    if (xfer_done !== 1'b1 || xfer_err !== 1'b0 || xfer_id !== 2'd1) begin
      nFail++; $display("FAIL timeout_clear: got done=%b err=%b id=%0d required 1 0 1", xfer_done, xfer_err, xfer_id);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad = 0;
    ready = 1'b0;
    req_data[0 +: N] = 8'hC3;
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    repeat (500) begin
      if (validIn !== 1'b1 || xfer_done !== 1'b0 || xfer_err !== 1'b0) bad++;
      tick();
    end
    nTests++;
    if (bad != 0) begin nFail++; $display("FAIL no_timeout_hold: got %0d bad cycles required 0", bad); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_stale_ack();
    test_reset_mid();
`ifdef HS_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    tick();
    nTests++;
    if (sb.size() != 0) begin nFail++; $display("FAIL sb_empty: got %0d pending required 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
